dma_engine: RTL and testbench
=============================

Name: dma_engine

Overview:
Parametrised single-channel memory-to-memory DMA engine. It is the next generation of the team's 8-bit byte-copy DMA.
- The CPU programs source, destination, length and address modes, then pulses start.
- The engine moves DATA_W-wide words over a single shared memory port.
- Every read and write request is held until the memory acknowledges it.
- Adds abort, a wait-state watchdog, fixed or incrementing addressing, and an error status.

Parameters:
ADDR_W, 8, memory address width; pointers wrap modulo 2^ADDR_W
DATA_W, 8, data word width
LEN_W, 8, transfer length counter width (max 2^LEN_W-1 words)
TIMEOUT, 255, max cycles a request waits for mem_ready before error; 0 disables the watchdog

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; sampled only in IDLE
abort  in  1  level; terminates an active transfer
src_addr  in  ADDR_W  start source address
dst_addr  in  ADDR_W  start destination address
length  in  LEN_W  number of words to move
src_inc  in  1  1 = increment source pointer per word, 0 = fixed (peripheral FIFO)
dst_inc  in  1  same, for destination
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of transfer (any outcome)
err  out  2  status valid with done, held until next start: 0 ok, 1 aborted, 2 timeout
remaining  out  LEN_W  words not yet written
mem_addr  out  ADDR_W  memory address
mem_rd  out  1  read request, held until mem_ready
mem_wr  out  1  write request, held until mem_ready
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid when mem_ready with mem_rd
mem_ready  in  1  memory acknowledge for the current request

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy, done, mem_rd and mem_wr are 0; err, remaining, mem_addr and mem_wdata are 0; internal pointers and buffer are 0.
- All outputs are registered. mem_rd and mem_wr are never high together.
- A handshake completes on a rising edge where a request is high and mem_ready is high.
- IDLE:
  - On start, latch src/dst/length/inc flags; remaining <= length; err <= 0; busy <= 1.
  - If length==0: go to FINISH, with no memory access.
  - Otherwise go to READ: next cycle mem_rd=1, mem_addr=src.
- READ:
  - Hold mem_rd and mem_addr until mem_ready.
  - On handshake: buffer <= mem_rdata; mem_rd <= 0; mem_wr <= 1; mem_addr <= dst; mem_wdata <= mem_rdata; go to WRITE.
- WRITE:
  - Hold until mem_ready.
  - On handshake: remaining -= 1; src += src_inc; dst += dst_inc; mem_wr <= 0.
  - If remaining was 1: go to FINISH.
  - Otherwise go to READ, with mem_rd=1 and mem_addr=new src on the next cycle.
- Throughput with zero-wait memory: 2 cycles per word. Latency from start to first mem_rd: 1 cycle.
- FINISH: done=1 for exactly one cycle; busy=0 in the same cycle; return to IDLE.
  - A start in the FINISH cycle is ignored.
- start while busy: ignored; no effect on the transfer.
- abort while busy (READ/WRITE):
  - A handshake completing in the same cycle is honoured first (a write counts in remaining).
  - Then drop the request, err <= 1, go to FINISH.
  - abort in IDLE or FINISH is ignored.
- Watchdog:
  - The counter clears on every handshake and every state entry, and counts cycles a request is pending.
  - Reaching TIMEOUT without mem_ready: drop the request, err <= 2, go to FINISH.
  - abort has priority over timeout in the same cycle.
- Pointer arithmetic is modulo 2^ADDR_W; 0xFF+1 wraps to 0x00 at ADDR_W=8. There is no boundary error.
- remaining is frozen at its last value after an abort or timeout, for CPU inspection.

Decomposition:
- Package dma_pkg:
  - state enum IDLE/READ/WRITE/FINISH;
  - err code constants ERR_OK=0, ERR_ABORT=1, ERR_TIMEOUT=2.
- One sub-module, dma_watchdog: a parametrised TIMEOUT down-counter.
  - Inputs: clear, pending.
  - Output: expired, tied low when TIMEOUT=0.
- Everything else stays in dma_engine.

Test Plan:
1. Zero-wait memory (mem_ready tied 1), src=0x10, dst=0x80, length=4, both inc:
   - mem[0x80..0x83] equal mem[0x10..0x13];
   - done pulses on cycle 9 after start; err=0; remaining=0.
2. Fixed-source mode, src=0x20, src_inc=0, dst=0x40, length=3:
   - three reads of 0x20, writes to 0x40..0x42;
   - mem_rd held across 2 inserted wait cycles per read.
3. Wrap and edge cases:
   - dst=0xFE, length=4 -> writes land at 0xFE, 0xFF, 0x00, 0x01;
   - length=0 -> done one cycle after start, with no mem_rd/mem_wr activity.
4. Abort in WRITE with mem_ready high in the same cycle, length=5, after 2 words:
   - remaining=2, err=1, done pulses once;
   - mem_wr low the next cycle.
5. TIMEOUT=8, memory never asserts mem_ready on the first read:
   - mem_rd drops after 8 cycles; err=2; done=1; remaining=length.
6. rst_n asserted mid-WRITE:
   - mem_wr, busy and done go 0 immediately (asynchronously);
   - a new start after release runs a clean transfer.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and status codes for the single-channel memory-to-memory DMA engine.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ABORT   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/dma_watchdog.sv
// Wait-state watchdog: counts down while a memory request is pending, flags expiry
// on the TIMEOUT-th pending cycle. TIMEOUT=0 disables it.
module dma_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic pending,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear, pending};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;

      // cnt holds the number of pending cycles still allowed, including the current one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= CW'(TIMEOUT);
        end else if (clear) begin
          cnt <= CW'(TIMEOUT);
        end else if (pending && (cnt != '0)) begin
          cnt <= cnt - CW'(1);
        end
      end

      assign expired = pending && (cnt == CW'(1));
    end
  endgenerate

endmodule

// File: rtl/dma_engine.sv
// Single-channel memory-to-memory DMA: read one word, write it back, repeat,
// over a single shared memory port with abort, watchdog and error status.
module dma_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              src_inc,
  input  logic              dst_inc,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [LEN_W-1:0]  remaining,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // Memory handshake: mem_rd/mem_wr is a request that stays asserted with a stable
  // mem_addr (and mem_wdata) until a rising edge where mem_ready is also high; that
  // edge completes the transfer. At most one request is ever outstanding.

  state_e            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;
  logic              src_inc_q;
  logic              dst_inc_q;
  logic [DATA_W-1:0] buf_q;
  logic              hs;
  logic              active;
  logic              wd_clear;
  logic              wd_expired;

  assign hs        = (mem_rd | mem_wr) & mem_ready;
  assign active    = (state == READ) || (state == WRITE);
  assign wd_clear  = hs | ~active;
  assign src_next  = src_ptr + ADDR_W'(src_inc_q);
  assign dst_next  = dst_ptr + ADDR_W'(dst_inc_q);
  assign mem_wdata = buf_q;

  dma_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .pending (mem_rd | mem_wr),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      buf_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= ERR_OK;
      remaining <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            src_inc_q <= src_inc;
            dst_inc_q <= dst_inc;
            remaining <= length;
            err       <= ERR_OK;
            busy      <= 1'b1;
            if (length == '0) begin
              state <= FINISH;
            end else begin
              state    <= READ;
              mem_rd   <= 1'b1;
              mem_addr <= src_addr;
            end
          end
        end

        READ: begin
          if (hs) begin
            buf_q  <= mem_rdata;
            mem_rd <= 1'b0;
          end
          // a read completing alongside abort still lands in the buffer, but is not written
          if (abort) begin
            mem_rd <= 1'b0;
            err    <= ERR_ABORT;
            state  <= FINISH;
          end else if (hs) begin
            mem_wr   <= 1'b1;
            mem_addr <= dst_ptr;
            state    <= WRITE;
          end else if (wd_expired) begin
            mem_rd <= 1'b0;
            err    <= ERR_TIMEOUT;
            state  <= FINISH;
          end
        end

        WRITE: begin
          if (hs) begin
            remaining <= remaining - LEN_W'(1);
            src_ptr   <= src_next;
            dst_ptr   <= dst_next;
            mem_wr    <= 1'b0;
          end
          if (abort) begin
            mem_wr <= 1'b0;
            err    <= ERR_ABORT;
            state  <= FINISH;
          end else if (hs) begin
            if (remaining == LEN_W'(1)) begin
              state <= FINISH;
            end else begin
              state    <= READ;
              mem_rd   <= 1'b1;
              mem_addr <= src_next;
            end
          end else if (wd_expired) begin
            mem_wr <= 1'b0;
            err    <= ERR_TIMEOUT;
            state  <= FINISH;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
// Bench for dma_engine: a byte memory with programmable wait states, a table of
// directed transfers, hand-written corner sequences and randomized transfers.
module tb_dma_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic       src_inc;
  logic       dst_inc;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [7:0] remaining;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;

  dma_engine #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .LEN_W   (8),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .src_inc   (src_inc),
    .dst_inc   (dst_inc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and transaction logs ----------------
  logic [7:0] mem       [256];
  logic [7:0] model_mem [256];
  logic [7:0] rd_log_q[$];
  logic [7:0] wa_log_q[$];
  logic [7:0] wd_log_q[$];
  int         hold_log_q[$];
  logic [7:0] exp_ra_q[$];
  logic [7:0] exp_wa_q[$];
  logic [7:0] exp_wd_q[$];

  int wait_cfg    = 0;
  bit rand_waits  = 1'b0;
  bit never_ready = 1'b0;
  int wcnt        = 0;
  int cur_wait    = 0;
  int overlap_cnt = 0;

  // Decide mem_ready for the coming rising edge; a granted request completes there.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = 8'($urandom);
    if (mem_rd && mem_wr) overlap_cnt++;
    if (rst_n && (mem_rd || mem_wr)) begin
      if (wcnt == 0) cur_wait = rand_waits ? int'($urandom_range(0, 3)) : wait_cfg;
      if (!never_ready && wcnt >= cur_wait) begin
        mem_ready = 1'b1;
        if (mem_rd) begin
          mem_rdata = mem[mem_addr];
          rd_log_q.push_back(mem_addr);
          hold_log_q.push_back(wcnt + 1);
        end else begin
          mem[mem_addr] = mem_wdata;
          wa_log_q.push_back(mem_addr);
          wd_log_q.push_back(mem_wdata);
        end
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a copy moves words one at a time, reading before writing, pointers mod 256.
  task automatic model_xfer(input logic [7:0] s, input logic [7:0] d, input int n,
                            input logic si, input logic di);
    logic [7:0] ra;
    logic [7:0] wa;
    logic [7:0] data;
    for (int i = 0; i < n; i++) begin
      ra   = s + 8'(si ? i : 0);
      wa   = d + 8'(di ? i : 0);
      data = model_mem[ra];
      model_mem[wa] = data;
      exp_ra_q.push_back(ra);
      exp_wa_q.push_back(wa);
      exp_wd_q.push_back(data);
    end
  endtask

  task automatic compare_logs(input string tag, input int exp_hold);
    int mism;
    check({tag, "_nrd"}, rd_log_q.size(), exp_ra_q.size());
    check({tag, "_nwr"}, wa_log_q.size(), exp_wa_q.size());
    for (int i = 0; i < exp_ra_q.size() && i < rd_log_q.size(); i++) begin
      check($sformatf("%s_rd%0d_addr", tag, i), rd_log_q[i], exp_ra_q[i]);
      if (exp_hold >= 0) check($sformatf("%s_rd%0d_hold", tag, i), hold_log_q[i], exp_hold);
    end
    for (int i = 0; i < exp_wa_q.size() && i < wa_log_q.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), wa_log_q[i], exp_wa_q[i]);
      check($sformatf("%s_wr%0d_data", tag, i), wd_log_q[i], exp_wd_q[i]);
    end
    mism = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== model_mem[a]) mism++;
    check({tag, "_mem_bytes_differing"}, mism, 0);
    rd_log_q.delete(); wa_log_q.delete(); wd_log_q.delete(); hold_log_q.delete();
    exp_ra_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
  endtask

  // ---------------- driver ----------------
  // Cycle j is sampled 1 time unit after the j-th rising edge following the start edge (j=0).
  task automatic run_transfer(input string tag, input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] n, input logic si, input logic di,
                              input int poke, output int done_cyc, output int err_v,
                              output int rem_v, output int rd_cyc, output int first_rd);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; src_inc = si; dst_inc = di;
    start = 1'b1;
    done_cyc = -1; err_v = -1; rem_v = -1; rd_cyc = 0; first_rd = -1;
    for (int j = 0; j < 2000; j++) begin
      @(posedge clk); #1;
      if (j == 0) start = 1'b0;
      if (j == poke - 1) start = 1'b1;
      if (j == poke) start = 1'b0;
      if (mem_rd) begin
        rd_cyc++;
        if (first_rd < 0) first_rd = j;
      end
      if (done) begin
        done_cyc = j; err_v = err; rem_v = remaining;
        check({tag, "_busy_with_done"}, busy, 0);
        break;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) check({tag, "_done_within_budget"}, 0, 1);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_after_done"}, busy, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic       si;
    logic       di;
    int         waits;
    int         poke;
    int         exp_cyc;
    int         exp_err;
    int         exp_rem;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dc, ev, rv, rc, fr, cnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; src_inc = 1'b0; dst_inc = 1'b0;
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'($urandom);
      model_mem[a] = mem[a];
    end

    // start pulses in rows 0 and 3 land while busy / in the finishing cycle and must be ignored
    vecs[0] = '{8'h10, 8'h80, 8'd4, 1'b1, 1'b1, 0, 3, 9,  0, 0};
    vecs[1] = '{8'h20, 8'h40, 8'd3, 1'b0, 1'b1, 2, 0, 19, 0, 0};
    vecs[2] = '{8'h30, 8'hFE, 8'd4, 1'b1, 1'b1, 0, 0, 9,  0, 0};
    vecs[3] = '{8'h00, 8'h00, 8'd0, 1'b1, 1'b1, 0, 1, 1,  0, 0};
    vecs[4] = '{8'h50, 8'h60, 8'd2, 1'b1, 1'b0, 1, 0, 9,  0, 0};
    vecs[5] = '{8'hFD, 8'h10, 8'd5, 1'b1, 1'b1, 0, 0, 11, 0, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_remaining", remaining, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      wait_cfg = vecs[i].waits;
      model_xfer(vecs[i].src, vecs[i].dst, int'(vecs[i].len), vecs[i].si, vecs[i].di);
      run_transfer($sformatf("v%0d", i), vecs[i].src, vecs[i].dst, vecs[i].len,
                   vecs[i].si, vecs[i].di, vecs[i].poke, dc, ev, rv, rc, fr);
      check($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_cyc);
      check($sformatf("v%0d_err", i), ev, vecs[i].exp_err);
      check($sformatf("v%0d_remaining", i), rv, vecs[i].exp_rem);
      if (vecs[i].len != 0) check($sformatf("v%0d_first_rd_cycle", i), fr, 0);
      else check($sformatf("v%0d_rd_cycles", i), rc, 0);
      compare_logs($sformatf("v%0d", i), vecs[i].waits + 1);
    end
    wait_cfg = 0;

    // abort while idle has no effect
    cnt = 0;
    @(negedge clk) abort = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || done || mem_rd || mem_wr) cnt++;
    end
    abort = 1'b0;
    check("idle_abort_activity", cnt, 0);

    // abort in WRITE coinciding with the third write handshake
    model_xfer(8'h70, 8'hB0, 3, 1'b1, 1'b1);
    @(negedge clk);
    src_addr = 8'h70; dst_addr = 8'hB0; length = 8'd5; src_inc = 1'b1; dst_inc = 1'b1;
    start = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      @(posedge clk); #1;
      if (j == 0) start = 1'b0;
    end
    check("abort_pre_in_write", mem_wr, 1);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_mem_wr_dropped", mem_wr, 0);
    check("abort_mem_rd_low", mem_rd, 0);
    check("abort_err", err, 1);
    check("abort_remaining", remaining, 2);
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("abort_done_pulses", cnt, 1);
    check("abort_err_held", err, 1);
    check("abort_remaining_frozen", remaining, 2);
    compare_logs("abort", 1);

    // watchdog: the first read never gets mem_ready
    never_ready = 1'b1;
    run_transfer("tmo", 8'h33, 8'h44, 8'd3, 1'b1, 1'b1, 0, dc, ev, rv, rc, fr);
    never_ready = 1'b0;
    check("tmo_rd_cycles", rc, 8);
    check("tmo_done_cycle", dc, 9);
    check("tmo_err", ev, 2);
    check("tmo_remaining", rv, 3);
    compare_logs("tmo", -1);

    // asynchronous reset in the middle of a write
    @(negedge clk);
    src_addr = 8'h10; dst_addr = 8'hA0; length = 8'd4; src_inc = 1'b1; dst_inc = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("arst_pre_in_write", mem_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_wr", mem_wr, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_remaining", remaining, 0);
    check("arst_reads_seen", rd_log_q.size(), 1);
    check("arst_writes_seen", wa_log_q.size(), 0);
    rd_log_q.delete(); hold_log_q.delete();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_xfer(8'h10, 8'hA0, 4, 1'b1, 1'b1);
    run_transfer("arst_clean", 8'h10, 8'hA0, 8'd4, 1'b1, 1'b1, 0, dc, ev, rv, rc, fr);
    check("arst_clean_done_cycle", dc, 9);
    check("arst_clean_err", ev, 0);
    check("arst_clean_remaining", rv, 0);
    compare_logs("arst_clean", 1);

    // randomized transfers with random wait states
    rand_waits = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] s, d, n;
      logic si, di;
      s  = 8'($urandom);
      d  = 8'($urandom);
      n  = 8'($urandom_range(0, 12));
      si = 1'($urandom);
      di = 1'($urandom);
      model_xfer(s, d, int'(n), si, di);
      run_transfer($sformatf("rnd%0d", k), s, d, n, si, di, 0, dc, ev, rv, rc, fr);
      check($sformatf("rnd%0d_err", k), ev, 0);
      check($sformatf("rnd%0d_remaining", k), rv, 0);
      compare_logs($sformatf("rnd%0d", k), -1);
    end
    rand_waits = 1'b0;

    check("rd_wr_overlap_cycles", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
